// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: 2-flop sync, stability filter, Gray-code tracker, en/cw/err pulses.
// `QUAD_X4_EN selects x4 decoding; the default build counts one step per electrical cycle (x1).
module quad_decoder #(
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic en,
    output logic cw,
    output logic err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_ab_prev;
    logic [1:0]       r_ab_f;
    logic [1:0]       w_ab_f_next;
    logic [1:0]       r_ab_old;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_upd;
    logic             w_upd_next;
    logic             r_en;
    logic             r_cw;
    logic             r_err;
    logic             w_en_next;
    logic             w_cw_next;
    logic             w_err_next;
    logic             w_diff;
    logic [1:0]       w_x;
    logic             w_single;
    logic             w_both;
    logic             w_is_cw;

    // State, filter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_sync1   <= 2'b00;
            r_sync2   <= 2'b00;
            r_ab_prev <= 2'b00;
            r_ab_f    <= 2'b00;
            r_ab_old  <= 2'b00;
            r_cnt     <= '0;
            r_upd     <= 1'b0;
            r_en      <= 1'b0;
            r_cw      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sync1   <= {a, b};
            r_sync2   <= r_sync1;
            r_ab_prev <= r_sync2;
            r_ab_f    <= w_ab_f_next;
            r_ab_old  <= r_ab_f;
            r_cnt     <= w_cnt_next;
            r_upd     <= w_upd_next;
            r_en      <= w_en_next;
            r_cw      <= w_cw_next;
            r_err     <= w_err_next;
        end
    end

    // Next-state: INIT counts raw stability, TRACK counts stability of a differing value
    always_comb begin
        w_state_next = r_state;
        w_ab_f_next  = r_ab_f;
        w_cnt_next   = '0;
        w_upd_next   = 1'b0;
        w_diff       = (r_state == ST_INIT) || (r_sync2 != r_ab_f);
        if (w_diff) begin
            w_cnt_next = (r_sync2 == r_ab_prev) ? r_cnt + CNT_W'(1) : CNT_W'(1);
            if (w_cnt_next == CNT_W'(FILT_CYCLES)) begin
                w_cnt_next  = '0;
                w_ab_f_next = r_sync2;
                if (r_state == ST_INIT) begin
                    w_state_next = ST_TRACK;
                end else begin
                    w_upd_next = 1'b1;
                end
            end
        end
    end

    // Classify the accepted old->new transition one cycle after the ab_f update
    always_comb begin
        w_x      = r_ab_old ^ r_ab_f;
        w_single = ^w_x;
        w_both   = &w_x;
        case ({r_ab_old, r_ab_f})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: w_is_cw = 1'b1;
            default:                            w_is_cw = 1'b0;
        endcase
        w_err_next = r_upd & w_both;
`ifdef QUAD_X4_EN
        w_en_next  = r_upd & w_single;
        w_cw_next  = w_en_next ? w_is_cw : r_cw;
`else
        w_en_next  = r_upd & w_single & (r_ab_f == 2'b00);
        w_cw_next  = w_en_next ? (r_ab_old == 2'b01) : r_cw;
`endif
    end

    assign en  = r_en;
    assign cw  = r_cw;
    assign err = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder at FILT_CYCLES=4 (x1 default, x4 with QUAD_X4_EN).
module tb_quad_decoder;

`ifdef QUAD_X4_EN
    localparam int X4 = 1;
`else
    localparam int X4 = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic a;
    logic b;
    logic en;
    logic cw;
    logic err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int w_en, w_err, w_both, first_en, first_err, drv;
    logic last_cw;

    quad_decoder #(.FILT_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .en (en),
        .cw (cw),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        w_en = 0; w_err = 0; w_both = 0; first_en = -1; first_err = -1;
        drv = cyc;
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (en === 1'b1) begin
                w_en++;
                last_cw = cw;
                if (first_en < 0) first_en = cyc;
            end
            if (err === 1'b1) begin
                w_err++;
                if (first_err < 0) first_err = cyc;
            end
            if (en === 1'b1 && err === 1'b1) w_both++;
        end
    endtask

    // Drive a new {a,b}, hold 10 cycles, check pulse count/latency/direction/err
    task automatic step(input logic [1:0] ab, input int exp_en, input logic exp_cw,
                        input int exp_err, input string tag);
        clr();
        {a, b} = ab;
        tick(10);
        check({tag, "_en"}, w_en, exp_en);
        if (exp_en > 0) check({tag, "_lat"}, first_en, drv + 7);
        check({tag, "_cw"}, cw, exp_cw);
        check({tag, "_err"}, w_err, exp_err);
        if (exp_err > 0) check({tag, "_errlat"}, first_err, drv + 7);
        check({tag, "_excl"}, w_both, 0);
    endtask

    initial begin
        // Reset with pins at 11, then INIT must settle on ab_f=11 silently
        rst = 1'b1; a = 1'b1; b = 1'b1;
        clr();
        tick(3);
        check("rst_en", en, 0);
        check("rst_cw", cw, 0);
        check("rst_err", err, 0);
        check("rst_state", int'(dut.r_state), 0);
        rst = 1'b0;
        tick(10);
        check("init_en", w_en + w_err, 0);
        check("init_state", int'(dut.r_state), 1);
        check("init_abf", dut.r_ab_f, 2'b11);

        // Restart from 00
        rst = 1'b1; a = 1'b0; b = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(10);
        check("init0_abf", dut.r_ab_f, 2'b00);

        // CW sequence
        step(2'b10, X4, (X4 != 0), 0, "cw1");
        step(2'b11, X4, (X4 != 0), 0, "cw2");
        step(2'b01, X4, (X4 != 0), 0, "cw3");
        step(2'b00, 1,  1'b1,      0, "cw4");

        // Illegal jump keeps cw, then tracking resumes
        step(2'b11, 0,  1'b1, 1, "ill");
        check("ill_abf", dut.r_ab_f, 2'b11);
        step(2'b01, X4, 1'b1, 0, "ill_next");
        step(2'b00, 1,  1'b1, 0, "back0");

        // CCW sequence
        step(2'b01, X4, (X4 == 0), 0, "ccw1");
        step(2'b11, X4, (X4 == 0), 0, "ccw2");
        step(2'b10, X4, (X4 == 0), 0, "ccw3");
        step(2'b00, 1,  1'b0,      0, "ccw4");

        // 3-cycle glitch is rejected
        clr();
        a = 1'b1;
        tick(3);
        a = 1'b0;
        tick(12);
        check("gl3_en", w_en, 0);
        check("gl3_err", w_err, 0);
        check("gl3_abf", dut.r_ab_f, 2'b00);

        // 4-cycle pulse is exactly long enough: 00->10->00
        clr();
        a = 1'b1;
        tick(4);
        a = 1'b0;
        tick(14);
        check("gl4_en", w_en, (X4 != 0) ? 2 : 1);
        check("gl4_cw", last_cw, 1'b0);
        check("gl4_err", w_err, 0);
        check("gl4_abf", dut.r_ab_f, 2'b00);

        // Reset on the edge where a pending 01->00 pulse would rise
        step(2'b01, X4, 1'b0, 0, "pre");
        clr();
        {a, b} = 2'b00;
        tick(6);
        check("mid_pre_en", w_en, 0);
        rst = 1'b1;
        tick(1);
        check("mid_en", en, 0);
        check("mid_cw", cw, 0);
        check("mid_err", err, 0);
        check("mid_cnt", w_en, 0);
        check("mid_state", int'(dut.r_state), 0);
        rst = 1'b0;
        clr();
        tick(12);
        check("post_en", w_en + w_err, 0);
        check("post_state", int'(dut.r_state), 1);
        check("post_abf", dut.r_ab_f, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
